// File: rtl/dpram_stream_fifo_pkg.sv
// Shared definitions for the dual-port-RAM streaming FIFO controller.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   level_width()           : width of the occupancy count for a given ADDR_W
package dpram_stream_fifo_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;

  // Occupancy reaches DEPTH+2 at most, which fits in ADDR_W+1 bits for ADDR_W >= 2.
  function automatic int unsigned level_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/dpram_skid2.sv
// Two-entry output skid buffer with valid/ready handshake.
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : synchronous clear; drops any word captured this cycle
//   in_valid/in_data : word to capture (no ready; the producer guarantees room)
//   out_valid/out_ready/out_data : registered head of the buffer
//   cnt              : number of words held (0..2)
module dpram_skid2
  import dpram_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;
  logic [1:0]        occ_after_pop;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    cnt_d         = cnt_q;
    pop           = (cnt_q != 2'd0) & out_ready;
    occ_after_pop = cnt_q - {1'b0, pop};
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop) head_d = tail_q;
      // The incoming word lands in the first free slot after this cycle's pop.
      if (in_valid) begin
        if (occ_after_pop == 2'd0) head_d = in_data;
        else                       tail_d = in_data;
      end
      cnt_d = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/dpram_stream_fifo.sv
// Streaming FIFO controller in front of an external 2**ADDR_W x DATA_W
// dual-port RAM with 1-cycle registered read.
//   clk, rst_n, flush                 : clock, async active-low reset, sync clear
//   in_valid/in_ready/in_data         : write stream, becomes RAM port-A writes
//   out_valid/out_ready/out_data      : first-word-fall-through output stream
//   level                             : words held (RAM + read in flight + skid)
//   ram_we_a/ram_addr_a/ram_data_a    : RAM port A (write)
//   ram_we_b/ram_addr_b/ram_data_b    : RAM port B (read only, write tied off)
//   ram_q_b                           : RAM port-B read data, one cycle after address
module dpram_stream_fifo
  import dpram_stream_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [level_width(ADDR_W)-1:0] level,
  output logic                           ram_we_a,
  output logic [ADDR_W-1:0]              ram_addr_a,
  output logic [DATA_W-1:0]              ram_data_a,
  output logic                           ram_we_b,
  output logic [ADDR_W-1:0]              ram_addr_b,
  output logic [DATA_W-1:0]              ram_data_b,
  input  logic [DATA_W-1:0]              ram_q_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = level_width(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [LVL_W-1:0]  ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        skid_cnt;
  logic              push, pop, rd;
  logic [2:0]        pending;

  always_comb begin
    in_ready = (ram_cnt_q < LVL_W'(DEPTH)) & ~flush;
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    // Skid slots that will be committed once this cycle's pop retires.
    pending  = {1'b0, skid_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    rd       = (ram_cnt_q != '0) & (pending < 3'd2) & ~flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_b_d   = addr_b_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = 1'b0;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      addr_b_d  = '0;
      ram_cnt_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_b_d = rd_ptr_q;
      end
      ram_cnt_d  = ram_cnt_q + LVL_W'(push) - LVL_W'(rd);
      inflight_d = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_b_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_b_q   <= addr_b_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr_q;
  assign ram_data_a = push ? in_data : '0;
  assign ram_we_b   = 1'b0;
  assign ram_data_b = '0;
  assign ram_addr_b = rd ? rd_ptr_q : addr_b_q;
  assign level      = ram_cnt_q + LVL_W'(inflight_q) + LVL_W'(skid_cnt);

  // Flush also drops the capture of a read issued before the flush cycle.
  dpram_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (inflight_q),
    .in_data   (ram_q_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cnt       (skid_cnt)
  );

endmodule

// File: tb/tb_dpram_stream_fifo.sv
module tb_dpram_stream_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [6:0] level;
  logic       ram_we_a;
  logic [5:0] ram_addr_a;
  logic [7:0] ram_data_a;
  logic       ram_we_b;
  logic [5:0] ram_addr_b;
  logic [7:0] ram_data_b;
  logic [7:0] ram_q_b = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_stream_fifo #(
    .ADDR_W (6),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b),
    .ram_q_b    (ram_q_b)
  );

  // 64x8 RAM: registered read, read-during-write returns old data.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rcv, sent, gaps, wraps, first, empty_err, lvl_err;
    logic [5:0] prev_addr;
    logic [7:0] q[$];

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

    // ---- reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_we_a", ram_we_a, 0);
    chk("rst_addr_a", ram_addr_a, 0);
    chk("rst_data_a", ram_data_a, 0);
    chk("rst_addr_b", ram_addr_b, 0);
    chk("rst_we_b", ram_we_b, 0);
    chk("rst_data_b", ram_data_b, 0);
    step();
    rst_n = 1'b1;
    step();

    // ---- single word, latency 3
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    chk("c0_we_a", ram_we_a, 1);
    chk("c0_addr_a", ram_addr_a, 0);
    chk("c0_data_a", ram_data_a, 8'hA5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("c1_addr_b", ram_addr_b, 0);
    chk("c1_we_a", ram_we_a, 0);
    chk("c1_level", level, 1);
    chk("c1_out_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("c2_q_b", ram_q_b, 8'hA5);
    chk("c2_out_valid", out_valid, 0);
    chk("c2_level", level, 1);
    step();
    @(negedge clk);
    chk("c3_out_valid", out_valid, 1);
    chk("c3_out_data", out_data, 8'hA5);
    step();
    @(negedge clk);
    chk("c4_out_valid", out_valid, 0);
    chk("c4_level", level, 0);
    step();

    // ---- fill to full with the output stalled
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1; in_data = 8'(acc);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_accepted", acc, 66);
    chk("full_level", level, 66);
    chk("full_in_ready", in_ready, 0);
    step();

    // ---- drain in order
    out_ready = 1'b1; rcv = 0;
    for (int c = 0; c < 200 && rcv < 66; c++) begin
      @(negedge clk);
      if (c == 0) chk("drain_in_ready0", in_ready, 0);
      if (c == 1) chk("drain_in_ready1", in_ready, 1);
      if (out_valid) begin
        chk("drain_data", out_data, 8'(rcv));
        rcv++;
      end
      step();
    end
    chk("drain_count", rcv, 66);
    @(negedge clk);
    chk("drain_level", level, 0);
    step();

    // ---- sustained streaming across pointer wrap
    sent = 0; rcv = 0; gaps = 0; wraps = 0; first = -1; prev_addr = 6'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && rcv < 200; c++) begin
      in_valid = (sent < 200); in_data = 8'(sent + 8'h30);
      @(negedge clk);
      if (ram_we_a) begin
        if (prev_addr == 6'd63 && ram_addr_a == 6'd0) wraps++;
        prev_addr = ram_addr_a;
      end
      if (in_valid && in_ready) sent++;
      if (rcv > 0 && !out_valid) gaps++;
      if (out_valid) begin
        if (rcv == 0) first = c;
        chk("wrap_data", out_data, 8'(rcv + 8'h30));
        rcv++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("wrap_count", rcv, 200);
    chk("wrap_first_cycle", first, 3);
    chk("wrap_gaps", gaps, 0);
    chk("wrap_addr_a_wraps", wraps, 3);

    // ---- random backpressure against a scoreboard
    sent = 0; rcv = 0; empty_err = 0; lvl_err = 0;
    for (int c = 0; c < 20000 && rcv < 1000; c++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (level != 7'(q.size()) || level > 7'd66) lvl_err++;
      if (out_valid && q.size() == 0) empty_err++;
      if (out_valid && out_ready && q.size() != 0) begin
        chk("rand_data", out_data, q.pop_front());
        rcv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rand_count", rcv, 1000);
    chk("rand_empty_valid", empty_err, 0);
    chk("rand_level", lvl_err, 0);
    step();
    step();

    // ---- flush with a read in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    flush = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_we_a", ram_we_a, 0);
    chk("flush_out_valid", out_valid, 1);
    chk("flush_out_data", out_data, 8'h11);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_out_valid", out_valid, 0);
    chk("post_flush_level", level, 0);
    step();
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    chk("post_flush_addr_a", ram_addr_a, 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("p1_out_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("p2_out_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("p3_out_valid", out_valid, 1);
    chk("p3_out_data", out_data, 8'h3C);
    step();
    @(negedge clk);
    chk("p4_out_valid", out_valid, 0);
    chk("p4_level", level, 0);
    step();

    // ---- async reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i); step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("pre_rst_level", level, 10);
    chk("pre_rst_out_valid", out_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
